// File: rtl/int_dist.sv
// int_dist: broadcasts one word from the clocks[0] control domain to every
// per-channel clock domain using an independent 4-phase req/ack handshake
// per channel. Completion is reported only after every channel has captured
// the word and released its acknowledge.
module int_dist #(
  parameter int CTR_NUMBER  = 16,
  parameter int DATA_W      = 10,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic [CTR_NUMBER-1:0]             clocks,
  input  logic                              rst,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic                              in_wr,
  output logic                              ready,
  output logic                              done,
  output logic                              overrun,
  output logic [CTR_NUMBER-1:0][DATA_W-1:0] out_data,
  output logic [CTR_NUMBER-1:0]             out_wr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  logic                                  clk0;
  state_t                                state;
  state_t                                state_nxt;
  logic                                  req;
  logic [DATA_W-1:0]                     hold;
  logic [CTR_NUMBER-1:0]                 ack;
  logic [CTR_NUMBER-1:0][SYNC_STAGES-1:0] ack_sync;
  logic [CTR_NUMBER-1:0]                 ack_s;
  logic                                  all_ack;
  logic                                  none_ack;

  assign clk0 = clocks[0];

  // ---------------------------------------------------------------------
  // Control side (clocks[0])
  // ---------------------------------------------------------------------

  // State register.
  // NOTE: every clocked block assigns with <= so that all flops sample the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode and Moore outputs.
  // NOTE: every output of this block is given a default before the case so
  // no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (in_wr) state_nxt = ST_REQ;
      end
      ST_REQ:  if (all_ack)  state_nxt = ST_REL;
      ST_REL:  if (none_ack) state_nxt = ST_DONE;
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // req is a dedicated flop so the signal crossing domains is glitch-free;
  // it is high exactly while the FSM sits in ST_REQ.
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) req <= 1'b0;
    else      req <= (state_nxt == ST_REQ);
  end

  // Capture the broadcast word on acceptance; it then stays frozen until the
  // FSM is back in ST_IDLE, so channels may sample it freely while req_s=1.
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst)                       hold <= '0;
    else if (state == ST_IDLE && in_wr) hold <= in_data;
  end

  // Flag a write that arrives while a transfer is still in flight.
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) overrun <= 1'b0;
    else      overrun <= in_wr && !ready;
  end

  // Bring every channel acknowledge back into clocks[0].
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      ack_sync <= '0;
    end else begin
      for (int i = 0; i < CTR_NUMBER; i++)
        ack_sync[i] <= {ack_sync[i][SYNC_STAGES-2:0], ack[i]};
    end
  end

  always_comb begin
    for (int i = 0; i < CTR_NUMBER; i++)
      ack_s[i] = ack_sync[i][SYNC_STAGES-1];
  end

  assign all_ack  = &ack_s;
  assign none_ack = ~|ack_s;

  // ---------------------------------------------------------------------
  // Channel side, one identical slice per clocks[i] (channel 0 included)
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < CTR_NUMBER; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic                   req_d;
    logic                   ack_q;
    logic                   wr_q;
    logic [DATA_W-1:0]      data_q;

    assign req_s = req_sync[SYNC_STAGES-1];

    // Synchronise req and keep a delayed copy for rising-edge detection.
    always_ff @(posedge clocks[i] or negedge rst) begin
      if (!rst) begin
        req_sync <= '0;
        req_d    <= 1'b0;
      end else begin
        req_sync <= {req_sync[SYNC_STAGES-2:0], req};
        req_d    <= req_s;
      end
    end

    // Capture hold once per request and echo the request as acknowledge.
    always_ff @(posedge clocks[i] or negedge rst) begin
      if (!rst) begin
        data_q <= '0;
        wr_q   <= 1'b0;
        ack_q  <= 1'b0;
      end else begin
        wr_q  <= req_s && !req_d;
        ack_q <= req_s;
        if (req_s && !req_d) data_q <= hold;
      end
    end

    assign ack[i]      = ack_q;
    assign out_wr[i]   = wr_q;
    assign out_data[i] = data_q;
  end

endmodule

// File: doc/int_dist.md
Name: int_dist

Overview:
- Broadcasts a DATA_W-bit word from the clocks[0] domain to every per-channel clock domain clocks[i]. This is the reverse direction of the channel-to-clocks[0] gather path; typical use is loading presets or thresholds into the integer/fractional counters.
- Each channel uses an independent 4-phase req/ack handshake through multi-flop synchronizers.
- The clocks[0] side reports completion only after every channel has captured the word and released its ack.

Parameters:
CTR_NUMBER, 16, number of channel clock domains
DATA_W, 10, broadcast word width
SYNC_STAGES, 2, synchronizer depth, both directions (legal: 2..4)

Ports:
clocks  input  CTR_NUMBER  per-channel clocks; clocks[0] also clocks the control side
rst  input  1  reset rst, asynchronous, active-low, all domains
in_data  input  DATA_W  word to broadcast (clocks[0] domain)
in_wr  input  1  write request, sampled on clocks[0]
ready  output  1  control side idle, write will be accepted (clocks[0])
done  output  1  one-cycle pulse: all channels captured and released (clocks[0])
overrun  output  1  one-cycle pulse: in_wr while ready=0 (clocks[0])
out_data  output  DATA_W x CTR_NUMBER  per-channel captured word, in clocks[i] domain
out_wr  output  CTR_NUMBER  one-cycle strobe in clocks[i] when out_data[i] updates

Behaviour:
- Reset, asynchronous in all domains:
  - state=ST_IDLE, ready=1, done=0, overrun=0.
  - req=0, all ack=0, all synchronizer flops=0.
  - out_data[i]=0, out_wr[i]=0, hold register=0.
- Control FSM, clocks[0], four states:
  - ST_IDLE: ready=1. When in_wr=1: hold<=in_data, go to ST_REQ.
  - ST_REQ: req=1. Wait for all_ack (AND of the synchronized acks), then go to ST_REL.
  - ST_REL: req=0. Wait for none_ack (NOR of the synchronized acks), then go to ST_DONE.
  - ST_DONE: done=1 for one cycle, then go to ST_IDLE.
  - Illegal state encodings go to ST_IDLE.
- req is a dedicated flop set or cleared on state entry; it must never be a combinational decode crossing domains.
- hold is unchanged from leaving ST_IDLE until re-entering ST_IDLE. It is the only data crossing domains and is quasi-static while any req_s is high.
- overrun=1 for one cycle on any clocks[0] edge where in_wr=1 and ready=0. The write is dropped and hold is unaffected.
- Channel i, all logic on clocks[i], channel 0 included (uniform, no bypass):
  - req is passed through SYNC_STAGES flops to give req_s; req_d is a one-cycle delayed copy of req_s.
  - On req_s=1 and req_d=0: out_data[i]<=hold, out_wr[i]<=1 for exactly one cycle.
  - ack[i]<=req_s, registered.
- Back in clocks[0], ack is passed through SYNC_STAGES flops per channel.
- Latency, all clocks identical and aligned, SYNC_STAGES=2, accept at edge 0:
  - out_wr[i] high during cycle 3–4 (after edge 3); out_data valid from edge 3.
  - all_ack seen at edge 5; ST_REL from edge 6.
  - none_ack at edge 11; done high edges 12–13; ready=1 from edge 13.
  - Each extra sync stage adds 4 cycles.
  - Asynchronous clocks add 0 to +1 cycles per crossing (4 crossings per transfer).
- Exactly one out_wr pulse per channel per accepted write, regardless of clock ratio.
- A slow or stopped clocks[i] holds the FSM in ST_REQ or ST_REL indefinitely; there is no timeout. ready stays 0, and further in_wr produce overrun.
- in_wr asserted in ST_DONE (ready=0): overrun pulses, write dropped. A write in the following ST_IDLE cycle is accepted.
- Reset asserted mid-transfer: immediate return to reset values in all domains; no out_wr may fire after rst low. After release the block is in ST_IDLE with no pending transfer.
- out_data[i] retains its value between transfers.

Test Plan:
1. All clocks = 50 MHz aligned; in_wr=1, in_data=10'h2A5 at edge 0 -> every out_wr[i] pulses once at edge 3; out_data[i]=10'h2A5; done at edge 12; ready=1 at edge 13.
2. clocks[i] periods 10..25 ns, mutually asynchronous; 200 random writes, each issued when ready=1 -> every channel receives all 200 words in order; out_wr count = 200 per channel; no overrun.
3. In_wr held high continuously with incrementing in_data -> only words accepted at ready=1 appear; overrun pulses on every non-ready in_wr cycle; out_data never shows a rejected word.
4. Stop clocks[7] during ST_REQ -> ready stays 0 and done never pulses; other channels get exactly one out_wr. Restart clocks[7] -> channel 7 captures the held word; done pulses once.
5. Assert rst at cycle 2 of a transfer (before any out_wr), release 5 cycles later -> no out_wr, out_data all 0, ready=1. A new write of 10'h155 then completes normally.
6. CTR_NUMBER=4, DATA_W=16, SYNC_STAGES=3; write 16'hBEEF -> out_wr at edge 4, done at edge 16, ready at edge 17 (aligned clocks).
